// File: rtl/warp_lsu.sv
// rtl/warp_lsu.sv - warp-wide load/store unit serialising per-thread requests onto one memory port
//
// Captures one warp memory instruction on start (IDLE only), computes every
// thread's byte address, flags misaligned active threads, then issues one
// request per remaining active thread in ascending thread order. At most one
// request is outstanding. Results are held with done until ack.
//
// Ports:
//   clk, reset (async, active-low)
//   start, we, size, is_unsigned, thread_mask, rs1, rs2, imm : instruction capture
//   mem_valid/mem_ready, mem_addr, mem_we, mem_wdata, mem_wstrb : request port
//   mem_resp_valid, mem_resp_data                               : response port
//   busy, done, ack, lsu_out, misaligned                        : scheduler side
module warp_lsu #(
    parameter int NUM_THREADS = 4,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          we,
    input  logic [1:0]                    size,
    input  logic                          is_unsigned,
    input  logic [NUM_THREADS-1:0]        thread_mask,
    input  logic [NUM_THREADS*DATA_W-1:0] rs1,
    input  logic [NUM_THREADS*DATA_W-1:0] rs2,
    input  logic [DATA_W-1:0]             imm,
    output logic                          mem_valid,
    input  logic                          mem_ready,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_we,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic [3:0]                    mem_wstrb,
    input  logic                          mem_resp_valid,
    input  logic [DATA_W-1:0]             mem_resp_data,
    output logic                          busy,
    output logic                          done,
    input  logic                          ack,
    output logic [NUM_THREADS*DATA_W-1:0] lsu_out,
    output logic [NUM_THREADS-1:0]        misaligned
);

    localparam int IDX_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;

    logic                            r_we;
    logic [1:0]                      r_size;
    logic                            r_unsigned;
    logic [NUM_THREADS*DATA_W-1:0]   r_rs2;
    logic [ADDR_W-1:0]               r_addr [NUM_THREADS];
    logic [NUM_THREADS-1:0]          r_pending;
    logic [NUM_THREADS-1:0]          r_misaligned;
    logic [NUM_THREADS*DATA_W-1:0]   r_lsu_out;
    logic [IDX_W-1:0]                r_cur;

    logic                            r_mem_valid;
    logic [ADDR_W-1:0]               r_mem_addr;
    logic                            r_mem_we;
    logic [DATA_W-1:0]               r_mem_wdata;
    logic [3:0]                      r_mem_wstrb;

    logic [DATA_W-1:0]               w_sum [NUM_THREADS];
    logic [NUM_THREADS-1:0]          w_mis_vec;
    logic                            w_unused_hi;
    logic [IDX_W-1:0]                w_sel;
    logic [ADDR_W-1:0]               w_sel_addr;
    logic [DATA_W-1:0]               w_sel_rs2;
    logic [DATA_W-1:0]               w_wdata;
    logic [3:0]                      w_wstrb;
    logic [ADDR_W-1:0]               w_cur_addr;
    logic [1:0]                      w_lane;
    logic [DATA_W-1:0]               w_shift;
    logic [DATA_W-1:0]               w_load_val;
    logic [NUM_THREADS-1:0]          w_cur_onehot;
    logic [NUM_THREADS-1:0]          w_pending_left;
    logic [NUM_THREADS-1:0]          w_start_pending;
    logic                            w_accept;
    logic                            w_present;
    logic                            w_handshake;
    logic                            w_resp;

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'd1:    return a[0];
            2'd2:    return 1'b0;
            default: return a != 2'b00;
        endcase
    endfunction

    // Per-thread address and alignment from the live instruction inputs.
    // Only the low ADDR_W bits of the sum form the address.
    always_comb begin
        w_unused_hi = 1'b0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            w_sum[t]     = rs1[t*DATA_W +: DATA_W] + imm;
            w_mis_vec[t] = is_misaligned(size, w_sum[t][1:0]);
            w_unused_hi  = w_unused_hi ^ (^w_sum[t][DATA_W-1:ADDR_W]);
        end
    end

    assign w_start_pending = thread_mask & ~w_mis_vec;

    // Lowest-index pending thread wins.
    always_comb begin
        w_sel = '0;
        for (int t = NUM_THREADS - 1; t >= 0; t--) begin
            if (r_pending[t]) begin
                w_sel = IDX_W'(t);
            end
        end
    end

    assign w_sel_addr = r_addr[w_sel];
    assign w_sel_rs2  = r_rs2[int'(w_sel)*DATA_W +: DATA_W];

    // Store data is replicated across lanes so the strobe alone selects bytes.
    always_comb begin
        case (r_size)
            2'd1: begin
                w_wdata = {2{w_sel_rs2[15:0]}};
                w_wstrb = w_sel_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'd2: begin
                w_wdata = {4{w_sel_rs2[7:0]}};
                w_wstrb = 4'b0001 << w_sel_addr[1:0];
            end
            default: begin
                w_wdata = w_sel_rs2;
                w_wstrb = 4'b1111;
            end
        endcase
        if (!r_we) begin
            w_wstrb = 4'b0000;
        end
    end

    // Load lane extraction for the thread currently awaiting its response.
    assign w_cur_addr = r_addr[r_cur];
    assign w_lane     = (r_size == 2'd1) ? {w_cur_addr[1], 1'b0} : w_cur_addr[1:0];
    assign w_shift    = mem_resp_data >> {w_lane, 3'b000};

    always_comb begin
        case (r_size)
            2'd1:    w_load_val = r_unsigned ? {16'h0000, w_shift[15:0]}
                                             : {{16{w_shift[15]}}, w_shift[15:0]};
            2'd2:    w_load_val = r_unsigned ? {24'h000000, w_shift[7:0]}
                                             : {{24{w_shift[7]}}, w_shift[7:0]};
            default: w_load_val = mem_resp_data;
        endcase
    end

    assign w_cur_onehot   = NUM_THREADS'(1) << r_cur;
    assign w_pending_left = r_pending & ~w_cur_onehot;

    // Next state and per-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_present   = 1'b0;
        w_handshake = 1'b0;
        w_resp      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (w_start_pending == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!r_mem_valid) begin
                    w_present = 1'b1;
                end else if (mem_ready) begin
                    w_handshake = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    w_resp      = 1'b1;
                    w_state_nxt = (w_pending_left == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                if (ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we         <= 1'b0;
            r_size       <= 2'd0;
            r_unsigned   <= 1'b0;
            r_rs2        <= '0;
            r_pending    <= '0;
            r_misaligned <= '0;
            r_lsu_out    <= '0;
            r_cur        <= '0;
            r_mem_valid  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
            r_mem_wstrb  <= 4'b0000;
            for (int t = 0; t < NUM_THREADS; t++) begin
                r_addr[t] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_we         <= we;
                r_size       <= size;
                r_unsigned   <= is_unsigned;
                r_rs2        <= rs2;
                r_pending    <= w_start_pending;
                r_misaligned <= thread_mask & w_mis_vec;
                r_lsu_out    <= '0;
                for (int t = 0; t < NUM_THREADS; t++) begin
                    r_addr[t] <= w_sum[t][ADDR_W-1:0];
                end
            end
            // Request fields are registered one cycle after entering ISSUE and
            // then held untouched until the handshake.
            if (w_present) begin
                r_cur       <= w_sel;
                r_mem_valid <= 1'b1;
                r_mem_addr  <= {w_sel_addr[ADDR_W-1:2], 2'b00};
                r_mem_we    <= r_we;
                r_mem_wdata <= w_wdata;
                r_mem_wstrb <= w_wstrb;
            end
            if (w_handshake) begin
                r_mem_valid <= 1'b0;
            end
            if (w_resp) begin
                r_pending <= w_pending_left;
                if (!r_we) begin
                    r_lsu_out[int'(r_cur)*DATA_W +: DATA_W] <= w_load_val;
                end
            end
        end
    end

    assign mem_valid  = r_mem_valid;
    assign mem_addr   = r_mem_addr;
    assign mem_we     = r_mem_we;
    assign mem_wdata  = r_mem_wdata;
    assign mem_wstrb  = r_mem_wstrb;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign lsu_out    = r_lsu_out;
    assign misaligned = r_misaligned;

endmodule

// File: tb/tb_warp_lsu.sv
// tb/tb_warp_lsu.sv - scoreboard testbench for warp_lsu
module tb_warp_lsu;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         we;
    logic [1:0]   size;
    logic         is_unsigned;
    logic [3:0]   thread_mask;
    logic [127:0] rs1;
    logic [127:0] rs2;
    logic [31:0]  imm;
    logic         mem_valid;
    logic         mem_ready;
    logic [7:0]   mem_addr;
    logic         mem_we;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_wstrb;
    logic         mem_resp_valid;
    logic [31:0]  mem_resp_data;
    logic         busy;
    logic         done;
    logic         ack;
    logic [127:0] lsu_out;
    logic [3:0]   misaligned;

    warp_lsu #(.NUM_THREADS(4), .DATA_W(32), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .we(we), .size(size),
        .is_unsigned(is_unsigned), .thread_mask(thread_mask), .rs1(rs1), .rs2(rs2),
        .imm(imm), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .busy(busy), .done(done), .ack(ack), .lsu_out(lsu_out), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic [127:0] lsu;
        logic [3:0]   mis;
        logic [31:0]  lat;
    } res_t;

    req_t req_q[$];
    res_t res_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_start = 0;
    int hs_count = 0;
    int stall_cnt = 0;
    int resp_extra = 0;
    int resp_cnt = 0;
    logic prev_done = 1'b0;
    logic [31:0] memw [0:63];
    logic [31:0] resp_word;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: ready (optionally stalled), response one cycle after the
    // handshake plus resp_extra cycles.
    always @(negedge clk) begin
        mem_resp_valid = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt = resp_cnt - 1;
            if (resp_cnt == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = resp_word;
            end
        end
        if (mem_valid && stall_cnt > 0) begin
            mem_ready = 1'b0;
            stall_cnt = stall_cnt - 1;
        end else begin
            mem_ready = 1'b1;
        end
        if (mem_valid && mem_ready && reset) begin
            resp_word = memw[mem_addr[7:2]];
            resp_cnt  = 1 + resp_extra;
            for (int b = 0; b < 4; b++) begin
                if (mem_we && mem_wstrb[b]) memw[mem_addr[7:2]][b*8 +: 8] = mem_wdata[b*8 +: 8];
            end
        end
    end

    // Monitor: compares every presented request and every done rise against the queues.
    always @(negedge clk) begin
        req_t r;
        res_t e;
        int   lat;
        #1;
        if (reset && mem_valid) begin
            checks++;
            if (req_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_req: got addr=%h we=%b expected no request", mem_addr, mem_we);
            end else begin
                r = req_q[0];
                if (mem_addr !== r.addr || mem_we !== r.we || mem_wstrb !== r.strb ||
                    (r.we && mem_wdata !== r.wdata)) begin
                    errors++;
                    $display("FAIL req: got addr=%h we=%b strb=%b wdata=%h expected addr=%h we=%b strb=%b wdata=%h",
                             mem_addr, mem_we, mem_wstrb, mem_wdata, r.addr, r.we, r.strb, r.wdata);
                end
                if (mem_ready) begin
                    void'(req_q.pop_front());
                    hs_count++;
                end
            end
        end
        if (reset && done && !prev_done) begin
            checks++;
            lat = cyc - t_start + 1;
            if (res_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no result");
            end else begin
                e = res_q.pop_front();
                if (lsu_out !== e.lsu || misaligned !== e.mis || lat !== int'(e.lat)) begin
                    errors++;
                    $display("FAIL result: got lsu=%h mis=%b lat=%0d expected lsu=%h mis=%b lat=%0d",
                             lsu_out, misaligned, lat, e.lsu, e.mis, e.lat);
                end
                if (req_q.size() != 0) begin
                    errors++;
                    $display("FAIL missing_req: got %0d outstanding expected 0", req_q.size());
                end
            end
        end
        prev_done = done;
    end

    task automatic push_req(input logic [7:0] a, input logic w, input logic [3:0] s, input logic [31:0] d);
        req_t r;
        r.addr = a; r.we = w; r.strb = s; r.wdata = d;
        req_q.push_back(r);
    endtask

    task automatic push_res(input logic [127:0] l, input logic [3:0] m, input int lat);
        res_t e;
        e.lsu = l; e.mis = m; e.lat = lat;
        res_q.push_back(e);
    endtask

    task automatic start_op(input logic w, input logic [1:0] sz, input logic u, input logic [3:0] m,
                            input logic [127:0] a, input logic [127:0] d, input logic [31:0] im);
        @(negedge clk);
        we = w; size = sz; is_unsigned = u; thread_mask = m; rs1 = a; rs2 = d; imm = im;
        start = 1'b1;
        t_start = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Pulse start with junk while the unit is busy; it must have no effect.
    task automatic junk_start();
        @(negedge clk);
        we = 1'b1; size = 2'd0; thread_mask = 4'b1111; rs1 = '0; rs2 = '1; imm = 32'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_op(input int hold);
        int n;
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL done_timeout: got done=0 expected done=1 within 300 cycles");
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #2;
            checks++;
            if (done !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL done_hold: got done=%b busy=%b expected 1 1", done, busy);
            end
        end
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        #2;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_ack: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    function automatic logic [127:0] p4(input logic [31:0] a0, input logic [31:0] a1,
                                        input logic [31:0] a2, input logic [31:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int base_hs;
        reset = 1'b0; start = 1'b0; we = 1'b0; size = 2'd0; is_unsigned = 1'b0;
        thread_mask = '0; rs1 = '0; rs2 = '0; imm = '0; ack = 1'b0;
        mem_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0; resp_word = '0;
        for (int i = 0; i < 64; i++) memw[i] = 32'h0;
        memw[0] = 32'hCAFEF00D;
        memw[2] = 32'h80017FFF;
        memw[3] = 32'h80FF7F01;
        memw[4] = 32'hDEAD0000;
        memw[5] = 32'h12345678;
        memw[6] = 32'h80000001;
        memw[7] = 32'h0F0FF0F0;
        #3;
        checks++;
        if ({mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, done, busy, lsu_out, misaligned} !== '0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b addr=%h wdata=%h strb=%b done=%b busy=%b lsu=%h mis=%b expected all 0",
                     mem_valid, mem_addr, mem_wdata, mem_wstrb, done, busy, lsu_out, misaligned);
        end
        @(negedge clk);
        reset = 1'b1;

        // Word load, four threads, plus an ignored start while busy.
        push_req(8'd16, 1'b0, 4'b0000, 32'h0);
        push_req(8'd20, 1'b0, 4'b0000, 32'h0);
        push_req(8'd24, 1'b0, 4'b0000, 32'h0);
        push_req(8'd28, 1'b0, 4'b0000, 32'h0);
        push_res(p4(32'hDEAD0000, 32'h12345678, 32'h80000001, 32'h0F0FF0F0), 4'b0000, 13);
        start_op(1'b0, 2'd0, 1'b0, 4'b1111, p4(0, 4, 8, 12), '0, 32'd16);
        junk_start();
        finish_op(0);

        // Half load, signed then unsigned.
        push_req(8'd8, 1'b0, 4'b0000, 32'h0);
        push_req(8'd8, 1'b0, 4'b0000, 32'h0);
        push_res(p4(32'h00007FFF, 32'hFFFF8001, 0, 0), 4'b0000, 7);
        start_op(1'b0, 2'd1, 1'b0, 4'b0011, p4(8, 10, 0, 0), '0, 32'd0);
        finish_op(0);
        push_req(8'd8, 1'b0, 4'b0000, 32'h0);
        push_req(8'd8, 1'b0, 4'b0000, 32'h0);
        push_res(p4(32'h00007FFF, 32'h00008001, 0, 0), 4'b0000, 7);
        start_op(1'b0, 2'd1, 1'b1, 4'b0011, p4(8, 10, 0, 0), '0, 32'd0);
        finish_op(0);

        // Word load with thread 1 misaligned at 0x13.
        push_req(8'd0, 1'b0, 4'b0000, 32'h0);
        push_req(8'd8, 1'b0, 4'b0000, 32'h0);
        push_req(8'd12, 1'b0, 4'b0000, 32'h0);
        push_res(p4(32'hCAFEF00D, 32'h0, 32'h80017FFF, 32'h80FF7F01), 4'b0010, 10);
        start_op(1'b0, 2'd0, 1'b0, 4'b1111, p4(0, 32'h13, 8, 12), '0, 32'd0);
        finish_op(0);

        // Signed byte load across all four lanes of 0x80FF7F01.
        for (int i = 0; i < 4; i++) push_req(8'd12, 1'b0, 4'b0000, 32'h0);
        push_res(p4(32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80), 4'b0000, 13);
        start_op(1'b0, 2'd2, 1'b0, 4'b1111, p4(0, 1, 2, 3), '0, 32'd12);
        finish_op(0);

        // Byte store, mask 0101 (thread 1 address would be odd but is masked off).
        push_req(8'd0, 1'b1, 4'b0010, 32'hABABABAB);
        push_req(8'd4, 1'b1, 4'b0100, 32'hCDCDCDCD);
        push_res('0, 4'b0000, 7);
        start_op(1'b1, 2'd2, 1'b0, 4'b0101, p4(1, 32'h13, 6, 0), p4(32'hAB, 32'h77, 32'hCD, 32'h99), 32'd0);
        finish_op(0);

        // Half store at offsets 0 and 2.
        push_req(8'h20, 1'b1, 4'b0011, 32'hBEEFBEEF);
        push_req(8'h20, 1'b1, 4'b1100, 32'hCAFECAFE);
        push_res('0, 4'b0000, 7);
        start_op(1'b1, 2'd1, 1'b0, 4'b0011, p4(32'h20, 32'h22, 0, 0), p4(32'h1234BEEF, 32'h0000CAFE, 0, 0), 32'd0);
        finish_op(0);

        // Illegal size behaves as word: thread 1 at 0x32 is misaligned.
        push_req(8'h30, 1'b1, 4'b1111, 32'h55AA1234);
        push_res('0, 4'b0010, 4);
        start_op(1'b1, 2'd3, 1'b0, 4'b0011, p4(32'h30, 32'h32, 0, 0), p4(32'h55AA1234, 32'h11111111, 0, 0), 32'd0);
        finish_op(0);

        // Empty mask, then all threads misaligned; done held for three cycles.
        push_res('0, 4'b0000, 1);
        start_op(1'b0, 2'd0, 1'b0, 4'b0000, p4(0, 4, 8, 12), '0, 32'd0);
        finish_op(3);
        push_res('0, 4'b1111, 1);
        start_op(1'b0, 2'd0, 1'b0, 4'b1111, p4(0, 4, 8, 12), '0, 32'd1);
        finish_op(3);

        // Stalled store, reset during WAIT_RESP, late response ignored.
        stall_cnt = 5;
        resp_extra = 4;
        base_hs = hs_count;
        push_req(8'h40, 1'b1, 4'b1111, 32'h11112222);
        start_op(1'b1, 2'd0, 1'b0, 4'b0011, p4(32'h40, 32'h44, 0, 0), p4(32'h11112222, 32'h33334444, 0, 0), 32'd0);
        junk_start();
        n = 0;
        while (hs_count == base_hs && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (hs_count == base_hs) begin
            checks++; errors++;
            $display("FAIL stall_handshake: got no handshake expected one within 50 cycles");
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, done, busy, lsu_out, misaligned} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%b addr=%h wdata=%h strb=%b done=%b busy=%b expected all 0",
                     mem_valid, mem_addr, mem_wdata, mem_wstrb, done, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #2;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || mem_valid !== 1'b0 || lsu_out !== '0) begin
                errors++;
                $display("FAIL post_reset_idle: got busy=%b done=%b valid=%b lsu=%h expected 0 0 0 0",
                         busy, done, mem_valid, lsu_out);
            end
        end
        stall_cnt = 0;
        resp_extra = 0;

        // Recovery after reset: single-thread word load.
        push_req(8'd24, 1'b0, 4'b0000, 32'h0);
        push_res(p4(0, 0, 32'h80000001, 0), 4'b0000, 4);
        start_op(1'b0, 2'd0, 1'b0, 4'b0100, p4(0, 0, 32'd8, 0), '0, 32'd16);
        finish_op(0);

        repeat (3) @(negedge clk);
        checks++;
        if (req_q.size() != 0 || res_q.size() != 0) begin
            errors++;
            $display("FAIL queues_empty: got req=%0d res=%0d expected 0 0", req_q.size(), res_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/warp_lsu.md
Name: warp_lsu

Overview:
- Warp-wide load/store unit; replaces per-thread LSU instances with a single block serving all threads of a warp.
- Captures a warp memory instruction, then issues one memory request per active thread, serialised in ascending thread index, over a single shared data-memory port.
- Supports word, halfword and byte accesses with sign or zero extension, byte write strobes, and misalignment detection.
- Sits between the warp scheduler/register file and the data-memory arbiter.

Parameters:
- NUM_THREADS, 4, threads per warp (1..32).
- DATA_W, 32, register/data width; fixed at 32 for strobe logic.
- ADDR_W, 8, data-memory byte-address width.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- start  in  1  pulse: accept instruction (honoured only in IDLE)
- we  in  1  1=store, 0=load
- size  in  2  0=word, 1=half, 2=byte, 3=illegal (treated as word)
- is_unsigned  in  1  zero-extend loads
- thread_mask  in  NUM_THREADS  active threads
- rs1  in  NUM_THREADS*DATA_W  per-thread base; thread t at [t*DATA_W +: DATA_W]
- rs2  in  NUM_THREADS*DATA_W  per-thread store data
- imm  in  DATA_W  shared offset
- mem_valid  out  1  request valid
- mem_ready  in  1  request accepted when mem_valid&&mem_ready
- mem_addr  out  ADDR_W  byte address, low 2 bits forced 0
- mem_we  out  1  write request
- mem_wdata  out  DATA_W  replicated store data
- mem_wstrb  out  4  byte enables; 0000 on loads
- mem_resp_valid  in  1  response valid (loads and stores)
- mem_resp_data  in  DATA_W  read word
- busy  out  1  state != IDLE
- done  out  1  results valid, held until ack
- ack  in  1  scheduler consumed results
- lsu_out  out  NUM_THREADS*DATA_W  per-thread load result
- misaligned  out  NUM_THREADS  per-thread misalignment flag

Behaviour:
- Reset is asynchronous, active-low, on `reset`; clock is `clk`. On reset: state=IDLE; mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, done, busy, lsu_out and misaligned all 0. Reset mid-transaction abandons it; no further request is issued.
- Address: addr_t = rs1_t + imm, truncated to ADDR_W.
- Misaligned if size=half and addr[0]=1, or size=word/illegal and addr[1:0]!=0.
- IDLE → ISSUE on start:
  - latch we, size, is_unsigned, rs2 and all per-thread addresses;
  - pending = thread_mask & ~misaligned_vec;
  - misaligned ← thread_mask & misaligned_vec;
  - clear lsu_out.
  - If pending==0, go to DONE instead (done rises next cycle).
- ISSUE: present the lowest pending thread p:
  - mem_valid=1, mem_addr={addr_p[ADDR_W-1:2],2'b00};
  - mem_wdata: word=rs2_p; half={2{rs2_p[15:0]}}; byte={4{rs2_p[7:0]}};
  - mem_wstrb: word=1111; half=0011 for offset 0, 1100 for offset 2; byte=0001<<addr[1:0]; 0000 if load.
  - Outputs hold stable until the handshake. On mem_valid&&mem_ready: deassert mem_valid next cycle and go to WAIT_RESP.
- WAIT_RESP: on mem_resp_valid, clear pending[p]. For loads, write extracted lane to lsu_out[p]:
  - half: bits [16*addr[1]+:16];
  - byte: bits [8*addr[1:0]+:8];
  - sign-extend unless is_unsigned.
  - Stores leave lsu_out[p]=0.
  - If pending is still nonzero go to ISSUE (next request one cycle later), else DONE.
- mem_resp_valid outside WAIT_RESP is ignored. At most one request is outstanding.
- DONE: done=1, lsu_out and misaligned stable. On ack go to IDLE; done clears the same edge. start in any non-IDLE state is ignored.
- Latency: k active aligned threads with zero-wait memory (ready and resp each one cycle after request) → done asserted 3k+1 cycles after start.

Test Plan:
- 4 threads, mask=1111, size=word load, rs1_t=4t, imm=16, memory words M[16..28]=A0,A1,A2,A3 → mem_addr sequence 16,20,24,28; lsu_out={A3,A2,A1,A0}; misaligned=0000; done after 13 cycles.
- Byte store, mask=0101, rs1_0=1, rs1_2=6, imm=0, rs2_0=0xAB, rs2_2=0xCD → two requests: addr 0 wstrb 0010 wdata 0xABABABAB; addr 4 wstrb 0100 wdata 0xCDCDCDCD; lsu_out all 0.
- Half load, memory word 0x8001_7FFF at addr 8, threads at 8 and 10, signed → 0x00007FFF and 0xFFFF8001; with is_unsigned=1 → 0x00007FFF and 0x00008001.
- Word load with thread 1 address 0x13 → misaligned=0010; only three requests issued; lsu_out[1]=0.
- mask=0000, or all threads misaligned → no mem_valid ever; done one cycle after start; held until ack, then idle.
- Reset asserted while in WAIT_RESP, plus mem_ready held low 5 cycles during ISSUE → mem_addr/wdata stable while stalled; after reset all outputs 0 and a late mem_resp_valid is ignored; start pulses while busy are ignored.
